xbee_rx: RTL and testbench
==========================

// Module: xbee_rx
// PURPOSE
//  - UART 8N1 receiver for the XBee link; counterpart of the 64-bit XBee transmitter.
//  - Deserialises NUM_BYTES consecutive bytes into one message word, emits a 1-cycle valid strobe.
//  - Sits between the XBee module's DOUT pin and the bot's command decoder, on the 50 MHz domain.
// PARAMETERS
//  CLKS_PER_BIT  434  clk_50M cycles per bit (115200 baud, matches TX divider 2*217)
//  NUM_BYTES     8    bytes per message; msg_data width = 8*NUM_BYTES
//  TIMEOUT_BITS  10   idle bit-times after a byte before a partial message is discarded
// PORTS
//  clk_50M      in   1   50 MHz clock, sole clock
//  rst          in   1   synchronous, active-high reset
//  rx           in   1   async serial input, idle high
//  msg_data     out  64  last complete message; first received byte in [63:56]
//  msg_valid    out  1   1-cycle pulse when msg_data updates
//  frame_err    out  1   1-cycle pulse: stop bit sampled low
//  msg_timeout  out  1   1-cycle pulse: partial message dropped on inter-byte gap
//  busy         out  1   high from start detect to end of stop bit
// BEHAVIOUR
//  - Reset: msg_data=0, msg_valid=0, frame_err=0, msg_timeout=0, busy=0, FSM=IDLE, byte_cnt=0.
//  - rx passes a 2-FF synchroniser (reset to 1); all timing below is relative to synced rx.
//  - Bit order LSB first in each byte; bytes fill the word MSB-byte first (byte k -> [63-8k -: 8]).
//  - FSM IDLE->START on synced rx falling to 0; bit counter cleared.
//  - START: wait CLKS_PER_BIT/2 cycles, resample; 1 -> IDLE (glitch, no error), 0 -> DATA.
//  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), 8 samples, then -> STOP.
//  - STOP: sample after CLKS_PER_BIT cycles. 1: store byte, byte_cnt++, -> IDLE.
//  - 0: frame_err pulse, byte_cnt=0, -> WAIT_HIGH; WAIT_HIGH -> IDLE when rx==1.
//  - byte_cnt reaching NUM_BYTES: msg_data loaded, msg_valid pulses the cycle after the stop sample,
//    byte_cnt=0. msg_data holds until the next complete message.
//  - Assembly buffer is separate from msg_data; partial messages never appear on msg_data.
//  - Timeout: in IDLE with byte_cnt>0, gap counter counts cycles; reaching TIMEOUT_BITS*CLKS_PER_BIT
//    -> msg_timeout pulse, byte_cnt=0. Gap counter clears on any start detect.
//  - Simultaneous start edge and timeout terminal count: timeout wins; the new byte begins a new message.
//  - Mid-operation rst: everything returns to reset values next edge; partial data lost.
//  - busy=1 in START/DATA/STOP/WAIT_HIGH.
//  - Counters sized $clog2 of their terminal values; no wrap (all counters cleared at terminal).
// CONFIGURATION
//  - XBEE_RX_MAJORITY_EN defined: each sample is the 2-of-3 majority of synced rx at
//    mid-1, mid, mid+1. The decision is taken at mid+1, so all sample points shift by +1 cycle.
//  - Undefined: single sample at mid-bit.
//  - Frame/timeout behaviour is identical either way.
// STRUCTURE
//  - Package xbee_pkg: rx state enum (IDLE,START,DATA,STOP,WAIT_HIGH), default CLKS_PER_BIT,
//    NUM_BYTES, shared with the TX side.
//  - Sub-module xbee_rx_byte: synchroniser + byte FSM -> byte, byte_strobe, frame_err.
//  - Top: message assembly, byte counter, timeout counter.
// TESTING
//  - Send 0x01..0x08 back-to-back at 434 clk/bit -> msg_data=64'h0102030405060708, one msg_valid.
//  - rx low for 100 cycles then high -> no byte, no frame_err, busy back to 0 within 218 cycles.
//  - Byte 0xA5 with stop bit 0 -> frame_err pulse, byte_cnt=0; then 8 good bytes -> correct msg.
//  - 3 bytes then 12 bit-times idle -> msg_timeout pulse, msg_data unchanged;
//    then 0x11..0x88 -> msg_data=64'h1122334455667788.
//  - rst pulsed during DATA of byte 5 -> all outputs 0; the next full message is received correctly.
//  - With XBEE_RX_MAJORITY_EN: 1-cycle inverted glitch at every mid-bit of 0x3C -> 0x3C received.
//    Without the macro -> corrupted byte.

Source files
------------

// File: rtl/xbee_pkg.sv
// xbee_pkg: receiver state encoding and link defaults shared by the XBee RX and TX sides.
package xbee_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_NUM_BYTES = 8;
endpackage

// File: rtl/xbee_rx_byte.sv
// xbee_rx_byte: rx synchroniser and 8N1 byte FSM producing byte, strobe and frame error.
// XBEE_RX_MAJORITY_EN selects 2-of-3 majority sampling around mid-bit (decided one cycle later).
module xbee_rx_byte import xbee_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_strobe_o,
  output logic       frame_err_o,
  output logic       start_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef XBEE_RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1 + OFS);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  rx_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] byte_q;
  logic rx_m_q, rx_s_q, strobe_q, ferr_q, sample;
`ifdef XBEE_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk_50M) hist_q <= rst ? 2'b11 : {hist_q[0], rx_s_q};
  assign sample = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s_q;
`endif
  assign byte_o = byte_q;
  assign byte_strobe_o = strobe_q;
  assign frame_err_o = ferr_q;
  assign start_o = (state_q == IDLE) && !rx_s_q;
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      strobe_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx_m_q <= rx_i;
      rx_s_q <= rx_m_q;
      strobe_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          cnt_q <= '0;
          bit_q <= '0;
        end
        START: if (cnt_q == HALF_T) begin
          cnt_q <= '0;
          state_q <= sample ? IDLE : DATA;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == FULL_T) begin
          cnt_q <= '0;
          byte_q <= {sample, byte_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (cnt_q == FULL_T) begin
          cnt_q <= '0;
          strobe_q <= sample;
          ferr_q <= !sample;
          state_q <= sample ? IDLE : WAIT_HIGH;
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/xbee_rx.sv
// xbee_rx: assembles NUM_BYTES received bytes into a message word with inter-byte timeout.
// XBEE_RX_MAJORITY_EN enables majority-vote bit sampling in the byte receiver.
module xbee_rx import xbee_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_BYTES = DEF_NUM_BYTES,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic                   clk_50M,
  input  logic                   rst,
  input  logic                   rx,
  output logic [8*NUM_BYTES-1:0] msg_data,
  output logic                   msg_valid,
  output logic                   frame_err,
  output logic                   msg_timeout,
  output logic                   busy
);
  localparam int W = 8 * NUM_BYTES;
  localparam int GAP_T = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW = $clog2(GAP_T);
  localparam int BW = $clog2(NUM_BYTES);
  logic [7:0] byte_w;
  logic strobe_w, start_w, timeout;
  logic [BW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic [W-1:0] buf_q, buf_d;
  xbee_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk_50M(clk_50M), .rst(rst), .rx_i(rx), .byte_o(byte_w), .byte_strobe_o(strobe_w),
    .frame_err_o(frame_err), .start_o(start_w), .busy_o(busy)
  );
  assign timeout = !busy && (cnt_q != '0) && (gap_q == GW'(GAP_T - 1));
  always_comb begin
    buf_d = buf_q;
    buf_d[8 * (NUM_BYTES - 1 - int'(cnt_q)) +: 8] = byte_w;
  end
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      msg_data <= '0;
      msg_valid <= 1'b0;
      msg_timeout <= 1'b0;
      cnt_q <= '0;
      gap_q <= '0;
      buf_q <= '0;
    end else begin
      msg_valid <= 1'b0;
      msg_timeout <= timeout;
      // timeout takes priority over a coinciding start detect
      gap_q <= (timeout || busy || start_w || cnt_q == '0) ? '0 : gap_q + 1'b1;
      if (timeout || frame_err) cnt_q <= '0;
      else if (strobe_w) begin
        buf_q <= buf_d;
        if (cnt_q == BW'(NUM_BYTES - 1)) begin
          cnt_q <= '0;
          msg_data <= buf_d;
          msg_valid <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xbee_rx.sv
// tb_xbee_rx: directed checks of message assembly, glitch rejection, framing, timeout and reset.
module tb_xbee_rx;
  localparam int CPB = 16;
  logic clk_50M = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [63:0] msg_data;
  logic msg_valid, frame_err, msg_timeout, busy;
  int passed = 0, checks = 0, nvalid = 0, nferr = 0, ntmo = 0;
  xbee_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(8), .TIMEOUT_BITS(10)) dut (
    .clk_50M(clk_50M), .rst(rst), .rx(rx), .msg_data(msg_data), .msg_valid(msg_valid),
    .frame_err(frame_err), .msg_timeout(msg_timeout), .busy(busy)
  );
  always #10 clk_50M = ~clk_50M;
  always @(negedge clk_50M) begin
    if (msg_valid) nvalid++;
    if (frame_err) nferr++;
    if (msg_timeout) ntmo++;
  end
  initial begin
    repeat (40000) @(posedge clk_50M);
    $display("FAIL watchdog: run did not end, got timeout expected completion");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask
  task automatic send_bit(input logic b, input bit g);
    rx = b;
    if (g) begin
      wait_clk(CPB / 2);
      rx = ~b;
      wait_clk(1);
      rx = b;
      wait_clk(CPB / 2 - 1);
    end else wait_clk(CPB);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop, input bit g);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], g);
    send_bit(stop, 1'b0);
    rx = 1'b1;
  endtask
  task automatic send_range(input logic [63:0] m, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send_byte(m[63-8*k -: 8], 1'b1, 1'b0);
  endtask
  initial begin
    logic [63:0] gexp;
    wait_clk(3);
    check("reset_msg_data", msg_data, 64'd0);
    check("reset_msg_valid", 64'(msg_valid), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_msg_timeout", 64'(msg_timeout), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    wait_clk(20);
    send_range(64'h0102030405060708, 0, 7);
    wait_clk(4);
    check("msg1_data", msg_data, 64'h0102030405060708);
    check("msg1_valid_count", 64'(nvalid), 64'd1);
    // short low pulse: start resample sees high again
    rx = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    check("glitch_busy_set", 64'(busy), 64'd1);
    for (int k = 0; k < 20 && busy; k++) wait_clk(1);
    check("glitch_busy_clear", 64'(busy), 64'd0);
    check("glitch_no_frame_err", 64'(nferr), 64'd0);
    wait_clk(20);
    send_byte(8'hA5, 1'b0, 1'b0);
    wait_clk(2);
    check("ferr_count", 64'(nferr), 64'd1);
    check("ferr_msg_held", msg_data, 64'h0102030405060708);
    wait_clk(40);
    send_range(64'hDEADBEEF01234567, 0, 7);
    wait_clk(4);
    check("after_ferr_msg", msg_data, 64'hDEADBEEF01234567);
    check("after_ferr_valid_count", 64'(nvalid), 64'd2);
    send_range(64'hAABBCC0000000000, 0, 2);
    wait_clk(12 * CPB);
    check("timeout_count", 64'(ntmo), 64'd1);
    check("timeout_msg_held", msg_data, 64'hDEADBEEF01234567);
    check("timeout_no_valid", 64'(nvalid), 64'd2);
    send_range(64'h1122334455667788, 0, 7);
    wait_clk(4);
    check("after_timeout_msg", msg_data, 64'h1122334455667788);
    send_range(64'h0F1E2D3C4B5A6978, 0, 2);
    wait_clk(8 * CPB);
    send_range(64'h0F1E2D3C4B5A6978, 3, 7);
    wait_clk(4);
    check("gap_below_timeout_msg", msg_data, 64'h0F1E2D3C4B5A6978);
    check("gap_below_timeout_count", 64'(ntmo), 64'd1);
    check("gap_valid_count", 64'(nvalid), 64'd4);
    send_range(64'h0102030405060708, 0, 3);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    rx = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rst_msg_data", msg_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_msg_valid", 64'(msg_valid), 64'd0);
    wait_clk(20);
    send_range(64'hCAFEF00D12345678, 0, 7);
    wait_clk(4);
    check("after_rst_msg", msg_data, 64'hCAFEF00D12345678);
    check("after_rst_valid_count", 64'(nvalid), 64'd5);
`ifdef XBEE_RX_MAJORITY_EN
    gexp = 64'h3C123456789ABCDE;
`else
    gexp = 64'hC3123456789ABCDE;
`endif
    send_byte(8'h3C, 1'b1, 1'b1);
    send_range(64'h3C123456789ABCDE, 1, 7);
    wait_clk(4);
    check("midbit_glitch_msg", msg_data, gexp);
    check("final_valid_count", 64'(nvalid), 64'd6);
    check("final_ferr_count", 64'(nferr), 64'd1);
    check("final_timeout_count", 64'(ntmo), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
